// File: rtl/lfsr_range_gen_if.sv
// Request/valid draw port and seed/run controls for the LFSR range generator.
interface lfsr_range_gen_if #(
   parameter int unsigned WIDTH = 16
);
   logic             seed_load;
   logic [WIDTH-1:0] seed;
   logic             run;
   logic             req;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic             busy;
   logic             valid;
   logic [WIDTH-1:0] value;
   logic [WIDTH-1:0] state;

   modport master (
      output seed_load, seed, run, req, lo, hi,
      input  busy, valid, value, state
   );

   modport slave (
      input  seed_load, seed, run, req, lo, hi,
      output busy, valid, value, state
   );
endinterface

// File: rtl/lfsr_range_gen.sv
// Fibonacci LFSR with seed load and lockup recovery; draws a value in [lo, hi]
// by rejection sampling, falling back to a halved candidate after MAX_TRIES.
module lfsr_range_gen #(
   parameter int unsigned WIDTH     = 16,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int unsigned MAX_TRIES = 8
) (
   input logic             clock,
   input logic             reset_n,
   lfsr_range_gen_if.slave bus
);

   typedef enum logic {StIdle, StDraw} fsm_e;

   // Tap masks: 1-based tap n maps to bit n-1.
   function automatic logic [15:0] tap_mask(input int unsigned w);
      case (w)
         3:       return 16'h0006;
         4:       return 16'h000C;
         5:       return 16'h0014;
         6:       return 16'h0030;
         7:       return 16'h0060;
         8:       return 16'h00B8;
         9:       return 16'h0110;
         10:      return 16'h0240;
         11:      return 16'h0500;
         12:      return 16'h0829;
         13:      return 16'h100D;
         14:      return 16'h2015;
         15:      return 16'h6000;
         default: return 16'hD008;
      endcase
   endfunction

   localparam logic [15:0]      TAPS16 = tap_mask(WIDTH);
   localparam logic [WIDTH-1:0] TAPS   = TAPS16[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];

   function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
      if (s == '0) return {{(WIDTH-1){1'b0}}, 1'b1};
      return {s[WIDTH-2:0], ^(s & TAPS)};
   endfunction

   // Smallest all-ones mask covering span: bit i set when span has any bit >= i.
   function automatic logic [WIDTH-1:0] cover_mask(input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] m;
      for (int i = 0; i < WIDTH; i++) m[i] = |(s >> i);
      return m;
   endfunction

   fsm_e             fsm_q, fsm_d;
   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] span_q, span_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [7:0]       tries_q, tries_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] cand;

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      span_d  = span_q;
      lo_d    = lo_q;
      mask_d  = mask_q;
      tries_d = tries_q;
      value_d = value_q;
      valid_d = 1'b0;
      cand    = state_q & mask_q;

      if (bus.seed_load) begin
         state_d = bus.seed;
         fsm_d   = StIdle;
      end else if (fsm_q == StDraw) begin
         state_d = lfsr_next(state_q);
         if (cand <= span_q) begin
            value_d = lo_q + cand;
            valid_d = 1'b1;
            fsm_d   = StIdle;
         end else if (32'(tries_q) + 32'd1 == MAX_TRIES) begin
            // cand <= 2*span+1 here, so cand>>1 never exceeds span.
            value_d = lo_q + (cand >> 1);
            valid_d = 1'b1;
            fsm_d   = StIdle;
         end else begin
            tries_d = tries_q + 8'd1;
         end
      end else if (bus.req) begin
         span_d  = (bus.hi >= bus.lo) ? bus.hi - bus.lo : '0;
         lo_d    = bus.lo;
         mask_d  = cover_mask(span_d);
         tries_d = '0;
         fsm_d   = StDraw;
      end else if (bus.run) begin
         state_d = lfsr_next(state_q);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q   <= StIdle;
         state_q <= SEED_W;
         span_q  <= '0;
         lo_q    <= '0;
         mask_q  <= '0;
         tries_q <= '0;
         value_q <= '0;
         valid_q <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         span_q  <= span_d;
         lo_q    <= lo_d;
         mask_q  <= mask_d;
         tries_q <= tries_d;
         value_q <= value_d;
         valid_q <= valid_d;
      end
   end

   assign bus.busy  = (fsm_q == StDraw);
   assign bus.valid = valid_q;
   assign bus.value = value_q;
   assign bus.state = state_q;

endmodule

// File: doc/lfsr_range_gen.md
# lfsr_range_gen

Parametrised maximal-length Fibonacci LFSR random source with seed load, free-run stepping, zero-lockup recovery and a request/valid draw port that returns a uniformly distributed value in a runtime range [lo, hi] by rejection sampling. It sits between the reaction-timer control FSM and the delay counter, supplying randomised wait times of configurable width. It replaces the fixed 3-bit and 4-bit generators.

## Interface
- WIDTH, 16, state/value width; legal 3..16
- SEED, 16'hACE1 (truncated to WIDTH), state loaded at reset; must be nonzero
- MAX_TRIES, 8, rejected evaluations allowed before fallback; legal 1..255
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- seed_load  in  1  load `seed` into state this cycle
- seed  in  WIDTH  seed value
- run  in  1  step state every cycle while IDLE
- req  in  1  draw request, sampled in IDLE
- lo, hi  in  WIDTH each  inclusive range, sampled with req
- busy  out  1  high while in DRAW
- valid  out  1  one-cycle pulse, `value` good
- value  out  WIDTH  drawn value, held until next valid
- state  out  WIDTH  raw LFSR state

## Operation
- Step: state <= {state[WIDTH-2:0], fb}, fb = XOR of tap bits (1-based n -> state[n-1]). If state == 0, step yields 1 (lockup recovery).
- Taps: 3:(3,2) 4:(4,3) 5:(5,3) 6:(6,5) 7:(7,6) 8:(8,6,5,4) 9:(9,5) 10:(10,7) 11:(11,9) 12:(12,6,4,1) 13:(13,4,3,1) 14:(14,5,3,1) 15:(15,14) 16:(16,15,13,4). Period 2^WIDTH-1.
- FSM states IDLE, DRAW.
- IDLE: req=1 -> register span = (hi>=lo) ? hi-lo : 0, lo_r = lo, mask = smallest 2^k-1 >= span (0 if span=0), tries = 0; go DRAW. Else if run=1, step.
- DRAW, each cycle: cand = state & mask.
  - cand <= span: value <= lo_r + cand, valid next cycle, step, -> IDLE.
  - else if tries+1 == MAX_TRIES: value <= lo_r + (cand >> 1) (always <= span), valid next cycle, step, -> IDLE.
  - else: step, tries++, stay.
- run is ignored in DRAW; exactly one step per cycle maximum.
- Priority: seed_load > DRAW > run. seed_load in DRAW aborts draw: no valid, -> IDLE, value unchanged.
- hi < lo: span=0, value = lo on first evaluation.
- No overflow: lo_r + cand <= hi.

## Timing
- Reset (async assert, sync-to-clock deassert assumed upstream): state = SEED, FSM IDLE, busy=0, valid=0, value=0, tries=0.
- req in IDLE at edge N -> busy=1 from N+1; first evaluation in cycle N+1; accepted first try -> valid=1, busy=0 in cycle N+2. Each rejection adds one cycle. Worst case valid at N+1+MAX_TRIES.
- valid cycle is IDLE: a req then starts a new draw (back-to-back, one draw per 2 cycles minimum).
- seed_load at edge N -> state = seed in cycle N+1; simultaneous req ignored.
- req while busy is ignored (not queued).

## Test plan
- WIDTH=4, seed_load 1, run=1 for 15 cycles -> state 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8,1 (period 15).
- WIDTH=4, seed 1, run=0, lo=0 hi=9, two reqs -> values 1 then 2, each valid 2 cycles after req, state ends 4.
- WIDTH=4, seed 11, lo=0 hi=2, MAX_TRIES=8 -> rejects 11,7,15 (cand 3), accepts 14 -> value 2, valid at N+5, busy N+1..N+4.
- Same with MAX_TRIES=2 -> fallback value 1 (3>>1) at N+3; lo=5 hi=7 seed 13 -> value 6.
- seed_load 0 -> state 0, next step -> 1; hi<lo (lo=9, hi=3) -> value 9.
- reset_n low mid-DRAW -> busy/valid/value 0 immediately, state = SEED; seed_load mid-DRAW -> no valid, IDLE next cycle.
